// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - MEM-stage load/store bus between pipeline (master) and data memory (slave)
interface data_mem_responder_if;
   logic        memRead;
   logic        memWrite;
   logic [31:0] addr;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        readValid;
   logic        memStall;
   logic        accessErr;

   modport master (
      output memRead, memWrite, addr, writeData,
      input  readData, readValid, memStall, accessErr
   );

   modport slave (
      input  memRead, memWrite, addr, writeData,
      output readData, readValid, memStall, accessErr
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data-memory responder that stalls the pipeline until each access completes
// Optional misaligned-request rejection: define DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_mem_responder_if.slave  bus
);
   localparam int ABITS = $clog2(DEPTH);
   localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [ABITS-1:0] idxQ;
   logic [31:0]      wdataQ;
   logic             opWrite;
   logic             req;
   logic             misaligned;
   logic             accept;
   logic             fire;
   logic [31:0]      mem [DEPTH];

   assign req = bus.memRead | bus.memWrite;

`ifdef DMEM_ALIGN_CHECK_EN
   assign misaligned    = (bus.addr[1:0] != 2'b00);
   assign bus.accessErr = rst_n && (state == IDLE) && req && misaligned;
`else
   assign misaligned    = 1'b0;
   assign bus.accessErr = 1'b0;
`endif

   // Word index only: upper address bits wrap, byte-offset bits are not part of the index.
   logic unusedAddr;
   assign unusedAddr = ^{bus.addr[31:ABITS+2], bus.addr[1:0]};

   assign accept = (state == IDLE) && req && !misaligned;
   assign fire   = (state == WAIT) && (cnt == '0);

   // Gated by rst_n so a held request cannot keep the pipeline frozen while in reset.
   assign bus.memStall = rst_n && (accept || (state == WAIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         idxQ          <= '0;
         wdataQ        <= '0;
         opWrite       <= 1'b0;
         bus.readData  <= '0;
         bus.readValid <= 1'b0;
      end else begin
         bus.readValid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  idxQ    <= bus.addr[ABITS+1:2];
                  wdataQ  <= bus.writeData;
                  opWrite <= bus.memWrite;
                  cnt     <= CNT_INIT;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state <= DONE;
                  if (!opWrite) begin
                     bus.readData  <= mem[idxQ];
                     bus.readValid <= 1'b1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Array write only on the final wait cycle; a reset before then leaves the array untouched.
   always_ff @(posedge clk) begin
      if (fire && opWrite) begin
         mem[idxQ] <= wdataQ;
      end
   end
endmodule
